cam_pwr_seq: RTL and testbench
==============================

# cam_pwr_seq

- Parametrised power-up/power-down sequencer for up to N_CAM camera modules.
- Replaces the single fixed-delay CAM_PWUP counter in the top level.
- Drives one power-enable line per camera and serves channels one at a time from a single shared timer, so rail inrush is staggered.
- Adds per-channel power-down with an enforced minimum off time, abort on request withdrawal, and a per-channel ready flag that gates SCCB traffic.

## Interface

Parameters:
- N_CAM, 2: number of camera channels, 1..8.
- PWUP_DELAY, 500000: cycles from accepted request to pwup assertion; ≥1.
- SETTLE_DELAY, 25000: cycles from pwup assertion to ready assertion; ≥1.
- OFF_MIN, 50000: minimum cycles a channel stays off after power-down or abort-from-settle; ≥1.

Ports:
- ila_clk, in, 1: clock.
- n_rst, in, 1: reset, synchronous, active-low.
- en, in, N_CAM: per-channel power request level. 1 = on, 0 = off.
- pwup, out, N_CAM: per-channel camera power enable (CAM_PWUP).
- ready, out, N_CAM: channel powered and settled; SCCB access allowed.
- busy, out, 1: sequencer not idle.
- active_ch, out, $clog2(N_CAM) (min 1): channel currently being sequenced. Valid only while busy.

## Operation

- States: IDLE, PU_DELAY, SETTLE, OFF_HOLD.
- Timer: one counter `cnt`, width $clog2(max(PWUP_DELAY, SETTLE_DELAY, OFF_MIN)) + 1. It is cleared on every state entry.
- **IDLE**
  - Select the lowest index i with en[i] != pwup[i]. Latch it into active_ch.
  - en[i]=1, pwup[i]=0: go to PU_DELAY.
  - en[i]=0, pwup[i]=1: clear pwup[i] and ready[i] on the same edge, then go to OFF_HOLD.
  - No mismatch: stay in IDLE.
- **PU_DELAY**
  - en[active_ch]=0 (abort): go to IDLE; pwup is never asserted; no off hold.
  - Else, when cnt == PWUP_DELAY-1: set pwup[active_ch], go to SETTLE.
  - Otherwise increment cnt.
- **SETTLE**
  - en[active_ch]=0 (abort): clear pwup[active_ch], go to OFF_HOLD.
  - Else, when cnt == SETTLE_DELAY-1: set ready[active_ch], go to IDLE.
- **OFF_HOLD**
  - When cnt == OFF_MIN-1: go to IDLE.
  - en changes on any channel are ignored while in this state.
- Abort check has priority over timer expiry on the same edge.
- Channels other than active_ch keep their pwup/ready unchanged while sequencing is in progress. Their en changes are serviced later, in index order.
- ready[i]=1 implies pwup[i]=1 at all times.
- busy = (state != IDLE), registered together with the state.

## Timing

- Reset (n_rst=0 at an edge), regardless of state:
  - pwup=0, ready=0, busy=0, active_ch=0, state IDLE, cnt=0.
  - en is ignored while n_rst=0.
  - Reset mid-sequence drops all power lines after the edge.
- Power-up, en[i] sampled high in IDLE at edge k:
  - busy=1 from k.
  - pwup[i]=1 after edge k+PWUP_DELAY.
  - ready[i]=1 and busy=0 after edge k+PWUP_DELAY+SETTLE_DELAY.
- Power-down, en[i] sampled low in IDLE at edge k:
  - pwup[i]=0 and ready[i]=0 after edge k.
  - busy=0 after edge k+OFF_MIN.
- Back-to-back: the next pending channel is sampled at the first edge after returning to IDLE. Consecutive power-ups are therefore spaced PWUP_DELAY+SETTLE_DELAY+1 cycles apart.
- Abort in PU_DELAY sampled at edge k: busy=0 after k.
- Abort in SETTLE sampled at edge k: pwup=0 after k; busy=0 after k+OFF_MIN.
- en is assumed synchronous to ila_clk; the caller synchronises it.

## Test plan

All scenarios use N_CAM=2, PWUP_DELAY=10, SETTLE_DELAY=5, OFF_MIN=4.

1. **Reset:** hold n_rst=0 for 3 edges with en=2'b11 → pwup=0, ready=0, busy=0 throughout; release → sequencing starts at the first sampled edge.
2. **Single power-up:** en=2'b01 sampled at edge 0 → busy=1 after edge 0; pwup=2'b01 after edge 10; ready=2'b01 and busy=0 after edge 15.
3. **Simultaneous requests:** en=2'b11 at edge 0 → channel 0 as in scenario 2. Channel 1 sampled at edge 16: pwup[1] after edge 26, ready[1] after edge 31. active_ch=1 from 16 to 31.
4. **Aborts:**
   - en[0] drops in PU_DELAY when cnt=5 → busy=0 next edge, pwup[0] never rises.
   - Repeat with the drop in SETTLE → pwup[0]=0 next edge, busy=0 four edges later.
5. **Power-down:** both channels ready, en 2'b11→2'b01 sampled at edge k → pwup=2'b01, ready=2'b01 after k; busy=1 until k+4. A re-raise of en[1] at k+1 is serviced only from edge k+5.
6. **Reset mid-op:** n_rst=0 during SETTLE of channel 1 with channel 0 ready → all outputs 0 after that edge. After release with en=2'b11, the full sequence restarts from channel 0.

Source files
------------

// File: rtl/cam_pwr_seq.sv
// Staggered power-up/power-down sequencer for N_CAM camera modules.
// One shared timer serves channels one at a time so rail inrush never overlaps.
module cam_pwr_seq #(
    parameter int N_CAM        = 2,
    parameter int PWUP_DELAY   = 500000,
    parameter int SETTLE_DELAY = 25000,
    parameter int OFF_MIN      = 50000,
    localparam int CH_W        = (N_CAM > 1) ? $clog2(N_CAM) : 1
) (
    input  logic             ila_clk,
    input  logic             n_rst,
    input  logic [N_CAM-1:0] en,
    output logic [N_CAM-1:0] pwup,
    output logic [N_CAM-1:0] ready,
    output logic             busy,
    output logic [CH_W-1:0]  active_ch
);

    localparam int MAX_A   = (PWUP_DELAY > SETTLE_DELAY) ? PWUP_DELAY : SETTLE_DELAY;
    localparam int MAX_DLY = (MAX_A > OFF_MIN) ? MAX_A : OFF_MIN;
    localparam int CNT_W   = $clog2(MAX_DLY) + 1;

    localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(PWUP_DELAY - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(SETTLE_DELAY - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_MIN - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PU_DELAY = 2'd1;
    localparam logic [1:0] S_SETTLE   = 2'd2;
    localparam logic [1:0] S_OFF_HOLD = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CH_W-1:0]  sel_nxt;
    logic [N_CAM-1:0] pwup_nxt, ready_nxt;
    logic [N_CAM-1:0] diff;
    logic [CH_W-1:0]  pick;
    logic             pick_vld;

    assign diff = en ^ pwup;

    // Lowest-index channel whose request disagrees with its power line.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = N_CAM - 1; i >= 0; i--) begin
            if (diff[i]) begin
                pick_vld = 1'b1;
                pick     = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        sel_nxt   = active_ch;
        pwup_nxt  = pwup;
        ready_nxt = ready;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (pick_vld) begin
                    sel_nxt = pick;
                    if (en[pick]) begin
                        state_nxt = S_PU_DELAY;
                    end else begin
                        pwup_nxt[pick]  = 1'b0;
                        ready_nxt[pick] = 1'b0;
                        state_nxt       = S_OFF_HOLD;
                    end
                end
            end
            S_PU_DELAY: begin
                // Withdrawal wins over expiry; the rail was never enabled.
                if (!en[active_ch]) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == PU_LAST) begin
                    pwup_nxt[active_ch] = 1'b1;
                    state_nxt           = S_SETTLE;
                    cnt_nxt             = '0;
                end
            end
            S_SETTLE: begin
                if (!en[active_ch]) begin
                    pwup_nxt[active_ch]  = 1'b0;
                    ready_nxt[active_ch] = 1'b0;
                    state_nxt            = S_OFF_HOLD;
                    cnt_nxt              = '0;
                end else if (cnt == ST_LAST) begin
                    ready_nxt[active_ch] = 1'b1;
                    state_nxt            = S_IDLE;
                    cnt_nxt              = '0;
                end
            end
            S_OFF_HOLD: begin
                if (cnt == OFF_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge ila_clk) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            active_ch <= '0;
            pwup      <= '0;
            ready     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            active_ch <= sel_nxt;
            pwup      <= pwup_nxt;
            ready     <= ready_nxt;
            busy      <= (state_nxt != S_IDLE);
        end
    end

    // SCCB gating relies on a channel never reporting ready while unpowered.
    assert property (@(posedge ila_clk) disable iff (!n_rst) (ready & ~pwup) == '0);

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with short delays (10/5/4) and two channels.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_cam_pwr_seq;

    logic       ila_clk;
    logic       n_rst;
    logic [1:0] en;
    logic [1:0] pwup;
    logic [1:0] ready;
    logic       busy;
    logic [0:0] active_ch;

    int checks = 0;
    int errors = 0;
    bit inv_on = 0;

    cam_pwr_seq #(
        .N_CAM       (2),
        .PWUP_DELAY  (10),
        .SETTLE_DELAY(5),
        .OFF_MIN     (4)
    ) dut (
        .ila_clk  (ila_clk),
        .n_rst    (n_rst),
        .en       (en),
        .pwup     (pwup),
        .ready    (ready),
        .busy     (busy),
        .active_ch(active_ch)
    );

    initial ila_clk = 1'b0;
    always #5 ila_clk = ~ila_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ila_clk);
            @(negedge ila_clk);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] p, input logic [1:0] r, input logic b);
        chk({tag, "_pwup"}, 32'(pwup), 32'(p));
        chk({tag, "_ready"}, 32'(ready), 32'(r));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    always @(negedge ila_clk) begin
        if (inv_on) chk("rdy_implies_pwup", 32'(ready & ~pwup), 32'd0);
    end

    initial begin
        n_rst = 1'b0;
        en    = 2'b11;

        // Reset held for three edges with both requests high
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_out("rst_hold", 2'b00, 2'b00, 1'b0);
            chk("rst_ach", 32'(active_ch), 32'd0);
        end
        inv_on = 1;

        // Release: edge 0 samples both requests, channel 0 first
        n_rst = 1'b1;
        step(1);
        chk_out("e0", 2'b00, 2'b00, 1'b1);
        chk("e0_ach", 32'(active_ch), 32'd0);
        step(9);
        chk_out("e9", 2'b00, 2'b00, 1'b1);
        step(1);
        chk_out("e10", 2'b01, 2'b00, 1'b1);
        step(4);
        chk_out("e14", 2'b01, 2'b00, 1'b1);
        step(1);
        chk_out("e15", 2'b01, 2'b01, 1'b0);
        step(1);
        chk_out("e16", 2'b01, 2'b01, 1'b1);
        chk("e16_ach", 32'(active_ch), 32'd1);
        step(9);
        chk_out("e25", 2'b01, 2'b01, 1'b1);
        step(1);
        chk_out("e26", 2'b11, 2'b01, 1'b1);
        chk("e26_ach", 32'(active_ch), 32'd1);
        step(5);
        chk_out("e31", 2'b11, 2'b11, 1'b0);
        chk("e31_ach", 32'(active_ch), 32'd1);
        step(1);
        chk_out("e32_idle", 2'b11, 2'b11, 1'b0);

        // Power-down of channel 1 with re-raise during the off hold
        en = 2'b01;
        step(1);
        chk_out("pd_k", 2'b01, 2'b01, 1'b1);
        chk("pd_ach", 32'(active_ch), 32'd1);
        en = 2'b11;
        step(1);
        chk_out("pd_k1", 2'b01, 2'b01, 1'b1);
        step(2);
        chk_out("pd_k3", 2'b01, 2'b01, 1'b1);
        step(1);
        chk_out("pd_k4", 2'b01, 2'b01, 1'b0);
        step(1);
        chk_out("pd_k5", 2'b01, 2'b01, 1'b1);
        chk("pd_k5_ach", 32'(active_ch), 32'd1);
        step(10);
        chk_out("pd_k15", 2'b11, 2'b01, 1'b1);
        step(5);
        chk_out("pd_k20", 2'b11, 2'b11, 1'b0);

        // Reset during SETTLE of channel 1 with channel 0 ready
        en = 2'b01;
        step(5);
        chk_out("rm_off", 2'b01, 2'b01, 1'b0);
        en = 2'b11;
        step(11);
        chk_out("rm_settle", 2'b11, 2'b01, 1'b1);
        step(2);
        n_rst = 1'b0;
        step(1);
        chk_out("rm_rst", 2'b00, 2'b00, 1'b0);
        chk("rm_rst_ach", 32'(active_ch), 32'd0);
        n_rst = 1'b1;
        step(1);
        chk_out("rm_r0", 2'b00, 2'b00, 1'b1);
        chk("rm_r0_ach", 32'(active_ch), 32'd0);
        step(10);
        chk_out("rm_r10", 2'b01, 2'b00, 1'b1);
        step(5);
        chk_out("rm_r15", 2'b01, 2'b01, 1'b0);
        step(1);
        chk("rm_r16_ach", 32'(active_ch), 32'd1);
        chk("rm_r16_busy", 32'(busy), 32'd1);

        // Clean slate for the abort cases
        n_rst = 1'b0;
        en    = 2'b00;
        step(1);
        n_rst = 1'b1;
        step(1);
        chk_out("ab_idle", 2'b00, 2'b00, 1'b0);

        // Abort in PU_DELAY when cnt reaches 5
        en = 2'b01;
        step(1);
        chk_out("ab_pu_e0", 2'b00, 2'b00, 1'b1);
        step(5);
        en = 2'b00;
        step(1);
        chk_out("ab_pu_drop", 2'b00, 2'b00, 1'b0);
        step(10);
        chk_out("ab_pu_after", 2'b00, 2'b00, 1'b0);

        // Abort in SETTLE
        en = 2'b01;
        step(11);
        chk_out("ab_st_pw", 2'b01, 2'b00, 1'b1);
        step(2);
        en = 2'b00;
        step(1);
        chk_out("ab_st_drop", 2'b00, 2'b00, 1'b1);
        step(3);
        chk_out("ab_st_k3", 2'b00, 2'b00, 1'b1);
        step(1);
        chk_out("ab_st_k4", 2'b00, 2'b00, 1'b0);

        inv_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
